flappy_game_ctrl: RTL
=====================

# flappy_game_ctrl

Game sequencer and obstacle scheduler for the flappy-box VGA display. Owns the game state machine, the position-update tick, bird vertical position, the obstacle slot pool (scroll, wrap, respawn height), and the score. Feeds registered coordinates to the pixel compositor and takes back its collision flag. Replaces the free-running slow-clock logic with clock-enable sequencing on the single system clock.

## Interface

Parameters:
- TICK_DIV, 524288: system-clock cycles per position-update tick (≥2)
- NUM_OBS, 3: obstacle slots (1..8)
- FLAP_DY, 20: upward pixels per flap

Ports:
- clk  in  1  100 MHz system clock; one clock, all logic on posedge
- rst  in  1  reset; synchronous, active-high
- up  in  1  flap button, already synchronized and debounced, level
- hit  in  1  collision flag from compositor (figure AND obstacle pixel), level
- tick  out  1  one-cycle pulse every TICK_DIV cycles
- bird_y  out  11  bird centre row
- obs_x  out  11*NUM_OBS  packed obstacle centre columns, slot i at [11i+10:11i]
- obs_y  out  11*NUM_OBS  packed obstacle centre rows, same packing
- score  out  8  obstacles passed, saturating
- game_state  out  2  current FSM state
- blank_screen  out  1  high in S_OVER; compositor forces black

## Operation

- Tick counter: 0..TICK_DIV-1, wraps; tick=1 when count==TICK_DIV-1. Runs in every state.
- Flap edge: up_q registers up; flap_edge = up & ~up_q.
- States (game_state encoding): S_READY=0, S_PLAY=1, S_OVER=2; 3 unused, decodes to S_READY.
- S_READY: bird_y=BIRD_Y0 (100), slots at init values, score=0. flap_edge -> S_PLAY; also sets flap_pending.
- S_PLAY, per tick: bird_y = flap_pending ? max(bird_y-FLAP_DY, 0) : bird_y+1; flap_pending cleared. flap_edge sets flap_pending at any cycle; a flap_edge coinciding with tick is applied on that tick.
- Per tick, each slot: x ≤ 2 -> x=SPAWN_X (679), y=80+rotl(lfsr,i) (80..335); else x=x-1, y held.
- Score: +1 per slot whose x goes 200 -> 199 on a tick (BIRD_X=200); saturates at 255.
- S_PLAY -> S_OVER when hit=1 (any cycle), or after a tick leaves bird_y ≤ 10 or ≥ 470. hit with tick in same cycle: transition taken, no position/score update that cycle.
- S_OVER: all positions and score frozen; blank_screen=1. flap_edge -> S_READY, reloading init values (score cleared).
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, steps every clock in all states (seed varies with player timing).
- Init values: slot i x=320+160i, y from {150,350,75,...} cycled by i.

## Timing

- All outputs registered. Reset values: tick=0, bird_y=100, obs_x/obs_y=init, score=0, game_state=S_READY, blank_screen=0, LFSR=8'hA5, counter=0, flap_pending=0.
- Updates land on the edge where tick=1; new values visible the following cycle.
- hit -> game_state=S_OVER and blank_screen=1 one cycle later.
- flap_edge -> state change one cycle later; up held high produces one edge only.
- rst mid-game: all reset values on the next edge, regardless of tick/hit.
- Width rule: all coordinates unsigned 11-bit; bird_y subtraction clamps at 0, never wraps.

## Structure

- Package flappy_pkg: state enum, BIRD_X, BIRD_Y0, SPAWN_X, WRAP_X=2, Y_MIN=10, Y_MAX=470, SPAWN_Y_BASE=80, init x/y tables, LFSR seed/taps.
- Sub-module flappy_lfsr8 (enable, seed load on rst); tick counter and FSM stay in the top.

## Test plan

- Reset, TICK_DIV=4: tick pulses at cycles 3,7,11; bird_y=100, obs_x slot0=320, state 0.
- up rising then 1 tick without flap: state 1; bird_y=80 after first tick (flap pending from start), 81 after next.
- Slot at x=3 then two ticks: x=2, then 679 with y in 80..335 matching LFSR model.
- Run until slot x 200 -> 199: score 0 -> 1; force score 255 path: stays 255.
- hit asserted in same cycle as tick: next cycle state 2, blank_screen=1, positions unchanged; further ticks change nothing.
- In S_OVER pulse up: state 0, bird_y=100, score=0; assert rst mid-S_PLAY: all reset values next cycle.

Source files
------------

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared state encoding, geometry constants and slot init tables for the flappy-box game controller
// Contents: state_t, playfield constants, LFSR seed/taps, init_x/init_y/spawn_y helpers.
package flappy_pkg;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    localparam logic [10:0] BIRD_X       = 11'd200;
    localparam logic [10:0] BIRD_Y0      = 11'd100;
    localparam logic [10:0] SPAWN_X      = 11'd679;
    localparam logic [10:0] WRAP_X       = 11'd2;
    localparam logic [10:0] Y_MIN        = 11'd10;
    localparam logic [10:0] Y_MAX        = 11'd470;
    localparam logic [10:0] SPAWN_Y_BASE = 11'd80;
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;
    // Feedback bits 7,5,4,3 realise x^8+x^6+x^5+x^4+1 in a left-shifting register.
    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;

    function automatic logic [10:0] init_x(input int i);
        return 11'(320 + 160 * i);
    endfunction

    function automatic logic [10:0] init_y(input int i);
        return (i % 3 == 0) ? 11'd150 : (i % 3 == 1) ? 11'd350 : 11'd75;
    endfunction

    // Each slot sees a different rotation of the shared LFSR so respawns decorrelate.
    function automatic logic [10:0] spawn_y(input logic [7:0] r, input int i);
        logic [7:0] s;
        s = (r << (i % 8)) | (r >> (8 - i % 8));
        return SPAWN_Y_BASE + {3'b000, s};
    endfunction

endpackage

// File: rtl/flappy_lfsr8.sv
// flappy_lfsr8: 8-bit Fibonacci LFSR for obstacle respawn heights, seeded on reset
// Ports: clk, rst (sync, active-high, loads seed), en (step enable), q (current state).
import flappy_pkg::*;

module flappy_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= LFSR_SEED;
        else if (en)
            q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game FSM, position tick, bird motion, obstacle slot pool and score for flappy-box
// Ports: clk, rst (sync, active-high); up (flap level), hit (collision level);
//        tick (update pulse), bird_y, obs_x/obs_y (11 bits per slot, packed), score, game_state, blank_screen.
import flappy_pkg::*;

module flappy_game_ctrl #(
    parameter int TICK_DIV = 524288,
    parameter int NUM_OBS  = 3,
    parameter int FLAP_DY  = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up,
    input  logic                   hit,
    output logic                   tick,
    output logic [10:0]            bird_y,
    output logic [11*NUM_OBS-1:0]  obs_x,
    output logic [11*NUM_OBS-1:0]  obs_y,
    output logic [7:0]             score,
    output logic [1:0]             game_state,
    output logic                   blank_screen
);

    localparam int          CW = $clog2(TICK_DIV);
    localparam logic [10:0] FD = 11'(FLAP_DY);

    logic [CW-1:0] cnt;
    logic          up_q, flap_edge, flap_pending, pend_n;
    logic [7:0]    lfsr, score_n;
    logic [10:0]   bird_n;
    logic [10:0]   x_q [NUM_OBS];
    logic [10:0]   y_q [NUM_OBS];
    logic [10:0]   x_n [NUM_OBS];
    logic [10:0]   y_n [NUM_OBS];
    logic [3:0]    passed;
    logic [8:0]    sum;
    state_t        state, state_n;

    flappy_lfsr8 u_lfsr (
        .clk(clk),
        .rst(rst),
        .en (1'b1),
        .q  (lfsr)
    );

    assign flap_edge  = up & ~up_q;
    assign game_state = state;
    assign score_n    = sum[8] ? 8'hFF : sum[7:0];

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
        assign obs_x[11*g +: 11] = x_q[g];
        assign obs_y[11*g +: 11] = y_q[g];
    end

    // tick is registered, so it is raised one count early to coincide with count==TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
            tick <= cnt == CW'(TICK_DIV - 2);
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = flap_pending | flap_edge;
        bird_n  = bird_y;
        x_n     = x_q;
        y_n     = y_q;
        passed  = '0;
        sum     = {1'b0, score};
        case (state)
            S_READY: state_n = flap_edge ? S_PLAY : S_READY;
            S_PLAY: begin
                // A collision wins over a coincident tick: the frame freezes as it was.
                if (hit)
                    state_n = S_OVER;
                else if (tick) begin
                    bird_n = pend_n ? (bird_y > FD ? bird_y - FD : '0) : bird_y + 11'd1;
                    pend_n = 1'b0;
                    for (int i = 0; i < NUM_OBS; i++) begin
                        passed = passed + {3'b000, x_q[i] == BIRD_X};
                        x_n[i] = (x_q[i] <= WRAP_X) ? SPAWN_X : x_q[i] - 11'd1;
                        y_n[i] = (x_q[i] <= WRAP_X) ? spawn_y(lfsr, i) : y_q[i];
                    end
                    sum     = {1'b0, score} + {5'b00000, passed};
                    state_n = (bird_n <= Y_MIN || bird_n >= Y_MAX) ? S_OVER : S_PLAY;
                end
            end
            S_OVER: begin
                if (flap_edge) begin
                    state_n = S_READY;
                    pend_n  = 1'b0;
                    bird_n  = BIRD_Y0;
                    sum     = '0;
                    for (int i = 0; i < NUM_OBS; i++) begin
                        x_n[i] = init_x(i);
                        y_n[i] = init_y(i);
                    end
                end
            end
            default: state_n = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_READY;
            up_q         <= 1'b0;
            flap_pending <= 1'b0;
            bird_y       <= BIRD_Y0;
            score        <= '0;
            blank_screen <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= init_x(i);
                y_q[i] <= init_y(i);
            end
        end else begin
            state        <= state_n;
            up_q         <= up;
            flap_pending <= pend_n;
            bird_y       <= bird_n;
            score        <= score_n;
            blank_screen <= state_n == S_OVER;
            x_q          <= x_n;
            y_q          <= y_n;
        end
    end

endmodule
